// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: ALUCtrl codes, FSM states and the shift-op decode shared by the execute ALU
package alu_exec_unit_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010
  } aluctrl_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
  function automatic logic is_shift(input logic [3:0] c);
    return c == ALU_SLL || c == ALU_SRL || c == ALU_SRA;
  endfunction
endpackage

// File: rtl/alu_exec_unit_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle shifter with a working register and a down-counter
module alu_shift_iter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               left_i,
  input  logic               arith_i,
  input  logic [XLEN-1:0]    a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               last_o,
  output logic [XLEN-1:0]    next_o
);
  logic [XLEN-1:0]    val_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               left_q, arith_q;
  // value after one more step; SRA re-inserts the top bit, which never changes during SRA
  always_comb begin
    next_o = left_q ? {val_q[XLEN-2:0], 1'b0} : {arith_q & val_q[XLEN-1], val_q[XLEN-1:1]};
    busy_o = cnt_q != '0;
    last_o = cnt_q == SHAMT_W'(1);
  end
  // load on accept, then shift and count down while work remains
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      val_q   <= a_i;
      cnt_q   <= shamt_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (busy_o) begin
      val_q <= next_o;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle logic/arith ops and iterative shifts
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      aluctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            done_o,
  output logic            illegal_o
);
  state_e             state_q, state_d;
  logic               hs, shift_op, sh_load, sh_busy, sh_last, sh_fin, legal, illegal_q;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res, fast_res, sh_next;
  assign hs       = valid_i & ready_o;
  assign shift_op = is_shift(aluctrl_i);
  assign shamt    = op_b_i[SHAMT_W-1:0];
  assign sh_load  = hs & shift_op & (shamt != '0);
  assign sh_fin   = (state_q == ST_SHIFT) & sh_last;
  assign fast_res = shift_op ? op_a_i : alu_res;
  alu_shift_iter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (sh_load),
    .left_i (aluctrl_i == ALU_SLL),
    .arith_i(aluctrl_i == ALU_SRA),
    .a_i    (op_a_i),
    .shamt_i(shamt),
    .busy_o (sh_busy),
    .last_o (sh_last),
    .next_o (sh_next)
  );
  // single-cycle datapath; unknown codes yield zero and flag illegal
  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    case (aluctrl_i)
      ALU_AND: alu_res = op_a_i & op_b_i;
      ALU_OR:  alu_res = op_a_i | op_b_i;
      ALU_ADD: alu_res = op_a_i + op_b_i;
      ALU_XOR: alu_res = op_a_i ^ op_b_i;
      ALU_SUB: alu_res = op_a_i - op_b_i;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = '0;
      default: legal = 1'b0;
    endcase
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // next state: DONE accepts a new request exactly like IDLE
  always_comb begin
    state_d = state_q == ST_SHIFT ? (sh_last ? ST_DONE : ST_SHIFT)
            : hs ? (sh_load ? ST_SHIFT : ST_DONE) : ST_IDLE;
  end
  // handshake and completion outputs
  always_comb begin
    ready_o   = (state_q != ST_SHIFT) & ~sh_busy;
    done_o    = state_q == ST_DONE;
    illegal_o = done_o & illegal_q;
  end
  // result registers load on the edge that enters DONE and hold otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o  <= '0;
      zero_o    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (hs & ~sh_load) begin
      result_o  <= fast_res;
      zero_o    <= fast_res == '0;
      illegal_q <= ~legal;
    end else if (sh_fin) begin
      result_o  <= sh_next;
      zero_o    <= sh_next == '0;
      illegal_q <= 1'b0;
    end
  end
endmodule
